// File: rtl/s0_rs_enc.sv
// Systematic RS(N,N-4) encoder over GF(2^8), primitive polynomial 0x11D.
// Message symbols pass straight through; four parity symbols produced by an
// LFSR divider with g(x) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40
// (roots alpha^0..alpha^3) are appended after the last message symbol.

// Constant-capable GF(2^8) multiplier, reduction polynomial 0x11D.
module gf2m8_multi (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] sh;

  // Shift-and-add: accumulate a*x^i for each set bit of b, reducing as a is shifted.
  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
  end

  assign p = acc;

endmodule

module s0_rs_enc #(
  parameter int N = 255  // codeword length, 5..255; K = N-4 message symbols
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enc_clr,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       dout_sop,
  output logic       dout_eop,
  output logic       dout_par
);

  localparam int         K      = N - 4;
  localparam logic [7:0] K_LAST = 8'(K - 1);

  // Generator polynomial coefficients below the monic x^4 term.
  localparam logic [7:0] G3 = 8'h0F;
  localparam logic [7:0] G2 = 8'h36;
  localparam logic [7:0] G1 = 8'h78;
  localparam logic [7:0] G0 = 8'h40;

  typedef enum logic {
    S_DATA = 1'b0,  // accepting message symbols
    S_PAR  = 1'b1   // emitting the four parity symbols
  } state_t;

  state_t     state;
  logic [7:0] cnt;   // message symbols accepted in the current codeword
  logic [1:0] pcnt;  // parity beat index
  logic [7:0] p0, p1, p2, p3;

  // Input handshake: a symbol is transferred on every rising edge where
  // din_vld and din_rdy are both high; din must be stable while din_vld is
  // high and din_rdy is low. din_vld may drop at any time. The output side
  // has no ready: each dout_vld cycle carries one symbol the consumer must take.
  logic accept;
  assign accept = din_vld & din_rdy;

  logic [7:0] fb;
  logic [7:0] m0, m1, m2, m3;
  assign fb = din ^ p3;

  gf2m8_multi u_mul3 (.a(fb), .b(G3), .p(m3));
  gf2m8_multi u_mul2 (.a(fb), .b(G2), .p(m2));
  gf2m8_multi u_mul1 (.a(fb), .b(G1), .p(m1));
  gf2m8_multi u_mul0 (.a(fb), .b(G0), .p(m0));

  // Encoder FSM: message pass-through with LFSR update, then a 4-beat parity flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_DATA;
      cnt      <= '0;
      pcnt     <= '0;
      p0       <= '0;
      p1       <= '0;
      p2       <= '0;
      p3       <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_par <= 1'b0;
      din_rdy  <= 1'b0;
    end else if (enc_clr) begin
      // Abort: discard any partial codeword, symbol on din is not taken.
      state    <= S_DATA;
      cnt      <= '0;
      pcnt     <= '0;
      p0       <= '0;
      p1       <= '0;
      p2       <= '0;
      p3       <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_par <= 1'b0;
      din_rdy  <= 1'b1;
    end else begin
      case (state)
        S_DATA: begin
          dout_vld <= accept;
          dout_sop <= 1'b0;
          dout_eop <= 1'b0;
          dout_par <= 1'b0;
          din_rdy  <= 1'b1;
          if (accept) begin
            dout     <= din;
            dout_sop <= (cnt == 8'd0);
            p3       <= p2 ^ m3;
            p2       <= p1 ^ m2;
            p1       <= p0 ^ m1;
            p0       <= m0;
            if (cnt == K_LAST) begin
              // Last message symbol: parity follows with no bubble.
              cnt     <= '0;
              state   <= S_PAR;
              din_rdy <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        S_PAR: begin
          dout     <= p3;
          dout_vld <= 1'b1;
          dout_sop <= 1'b0;
          dout_par <= 1'b1;
          dout_eop <= (pcnt == 2'd3);
          p3       <= p2;
          p2       <= p1;
          p1       <= p0;
          p0       <= '0;
          if (pcnt == 2'd3) begin
            // Register is all-zero after the fourth shift, ready for the next codeword.
            pcnt    <= '0;
            state   <= S_DATA;
            din_rdy <= 1'b1;
          end else begin
            pcnt    <= pcnt + 2'd1;
            din_rdy <= 1'b0;
          end
        end
        default: begin
          state   <= S_DATA;
          din_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule
